adder5_seq_ctrl: RTL and testbench
==================================

// Module: adder5_seq_ctrl
// PURPOSE
//  Multi-precision add sequencer. Adds two (5*NCHUNK)-bit operands using one shared
//  5-bit ripple adder (adder_5), one 5-bit chunk per clock, LSB chunk first.
//  The carry is held in a register between chunks. Valid/ready handshakes on both the
//  operand side and the result side let the block sit between a requester and a consumer.
// PARAMETERS
//  NCHUNK   4   number of 5-bit chunks; operand width = 5*NCHUNK; legal range 1..16
// PORTS
//  clk        in   1          single clock, rising edge
//  rst        in   1          asynchronous, active-high reset
//  in_valid   in   1          operand request
//  in_ready   out  1          block can accept operands
//  a          in   5*NCHUNK   operand A
//  b          in   5*NCHUNK   operand B
//  cin        in   1          carry-in into chunk 0
//  out_valid  out  1          result valid
//  out_ready  in   1          consumer accepts result
//  sum        out  5*NCHUNK   result
//  cout       out  1          carry out of the top chunk
//  busy       out  1          high in RUN or DONE
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, idx=0, carry reg=0, sum=0, cout=0,
//    out_valid=0, in_ready=1, busy=0. A reset in RUN or DONE discards the operation.
//  - IDLE: in_ready=1. When in_valid&in_ready: capture a, b and cin into operand regs
//    and the carry reg; idx<=0; go to RUN.
//  - RUN: in_ready=0. Each cycle adder_5 adds a_r[idx], b_r[idx] and the carry reg.
//    sum[idx]<=z; carry<=cout; idx<=idx+1. When idx==NCHUNK-1: cout<=adder cout; go to DONE.
//  - DONE: out_valid=1; sum and cout are stable. When out_ready=1: out_valid<=0; go to IDLE.
//  - Latency: out_valid rises NCHUNK clocks after the accepting edge.
//    Throughput is one operation per NCHUNK+2 cycles; DONE->IDLE has no bypass.
//  - in_valid outside IDLE is ignored. The operand regs are immune to changes on a/b.
//  - sum holds its last result in IDLE. While RUN is active, sum is updated chunk by chunk
//    and is valid only while out_valid=1.
//  - Wrap-around: the result is modulo 2^(5*NCHUNK); overflow shows only on cout.
//  - NCHUNK=1: RUN lasts exactly one cycle.
//  - idx width is $clog2(NCHUNK) (minimum 1 bit). idx never exceeds NCHUNK-1.
// CONFIGURATION
//  ADDER5_SEQ_SUB_EN defined: adds input port sub (1 bit), captured with the operands.
//    sub=1 computes a-b: b chunks are inverted into adder_5, the carry reg is loaded
//    with 1, and cin is ignored. cout=1 means no borrow (a>=b unsigned).
//    sub=0 gives identical behaviour to an undefined macro.
//  Undefined: no sub port; add only.
// STRUCTURE
//  - Package adder5_seq_pkg:
//    CHUNK_W=5 constant;
//    state enum {IDLE, RUN, DONE} (2-bit);
//    function chunk_sel(vec, idx) returning a 5-bit slice.
//  - One sub-module instance: adder_5 (existing 5-bit ripple adder), used as the only
//    arithmetic resource. The FSM, idx counter, operand/carry regs and the result register
//    stay in this module.
// TESTING (NCHUNK=4, 20-bit)
//  1. a=0x12345, b=0x0ABCD, cin=0 -> sum=0x1CF12, cout=0;
//     out_valid rises 4 clocks after accept.
//  2. a=0xFFFFF, b=0x00000, cin=1 -> sum=0x00000, cout=1 (full carry ripple across chunks).
//  3. Hold out_ready=0 for 3 cycles in DONE -> sum/cout stable, in_ready=0, a/b changes
//     have no effect; out_ready=1 -> IDLE next cycle, in_ready=1.
//  4. Assert rst in RUN at idx=2 -> all outputs reset at once, in_ready=1;
//     a new request a=1, b=1 then gives sum=0x00002.
//  5. Back-to-back in_valid held high with out_ready=1 -> accepts spaced 6 cycles
//     apart, no request lost.
//  6. ADDER5_SEQ_SUB_EN, sub=1, a=5, b=7 -> sum=0xFFFFE, cout=0;
//     a=7, b=5 -> sum=0x00002, cout=1.

Source files
------------

// File: rtl/adder5_seq_pkg.sv
// Shared types and helpers for the multi-precision add sequencer.
package adder5_seq_pkg;

  localparam int CHUNK_W    = 5;
  localparam int MAX_CHUNKS = 16;
  localparam int MAX_W      = CHUNK_W * MAX_CHUNKS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Callers zero-extend their operand to MAX_W so one helper serves every NCHUNK.
  function automatic logic [CHUNK_W-1:0] chunk_sel(input logic [MAX_W-1:0] vec,
                                                   input int unsigned      idx);
    return vec[idx*CHUNK_W +: CHUNK_W];
  endfunction

endpackage

// File: rtl/adder_5.sv
// 5-bit ripple-carry adder; the single arithmetic resource of the sequencer.
module adder_5
  import adder5_seq_pkg::*;
(
  input  logic [CHUNK_W-1:0] a_i,
  input  logic [CHUNK_W-1:0] b_i,
  input  logic               cin_i,
  output logic [CHUNK_W-1:0] z_o,
  output logic               cout_o
);

  logic [CHUNK_W:0] c;

  assign c[0] = cin_i;

  for (genvar i = 0; i < CHUNK_W; i++) begin : g_fa
    assign z_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = c[CHUNK_W];

endmodule

// File: rtl/adder5_seq_ctrl.sv
// Multi-precision add sequencer: one 5-bit chunk per clock, LSB first, through adder_5.
// Optional ADDER5_SEQ_SUB_EN adds a 'sub' port for a-b (cin ignored, cout=1 means no borrow).
module adder5_seq_ctrl
  import adder5_seq_pkg::*;
#(
  parameter int NCHUNK = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHUNK_W*NCHUNK-1:0] a,
  input  logic [CHUNK_W*NCHUNK-1:0] b,
  input  logic                      cin,
`ifdef ADDER5_SEQ_SUB_EN
  input  logic                      sub,
`endif
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHUNK_W*NCHUNK-1:0] sum,
  output logic                      cout,
  output logic                      busy
);

  localparam int W     = CHUNK_W * NCHUNK;
  localparam int IDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [W-1:0]       sum_q, sum_d;
  logic               cout_q, cout_d;
  logic [W-1:0]       a_q, b_q;
  logic               accept;
  logic               carry_load;
  logic [CHUNK_W-1:0] add_a, add_b_raw, add_b, add_z;
  logic               add_co;

  assign accept = (state_q == IDLE) && in_valid;

`ifdef ADDER5_SEQ_SUB_EN
  logic sub_q;

  always_ff @(posedge clk) begin
    if (accept) begin
      sub_q <= sub;
    end
  end

  // Subtraction is a + ~b + 1, so the initial carry replaces cin.
  assign carry_load = sub ? 1'b1 : cin;
  assign add_b      = sub_q ? ~add_b_raw : add_b_raw;
`else
  assign carry_load = cin;
  assign add_b      = add_b_raw;
`endif

  // Operands are captured once and are immune to later changes on a/b.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= b;
    end
  end

  assign add_a     = chunk_sel(MAX_W'(a_q), 32'(idx_q));
  assign add_b_raw = chunk_sel(MAX_W'(b_q), 32'(idx_q));

  adder_5 u_adder_5 (
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (carry_q),
    .z_o    (add_z),
    .cout_o (add_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          idx_d   = '0;
          carry_d = carry_load;
        end
      end
      RUN: begin
        sum_d[32'(idx_q)*CHUNK_W +: CHUNK_W] = add_z;
        carry_d = add_co;
        if (idx_q == IDX_LAST) begin
          cout_d  = add_co;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        // No bypass back into RUN: one idle cycle separates operations.
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_adder5_seq_ctrl.sv
// Self-checking bench for adder5_seq_ctrl (NCHUNK=4, 20-bit operands).
module tb_adder5_seq_ctrl;

  localparam int NCHUNK = 4;
  localparam int W      = 5 * NCHUNK;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
`ifdef ADDER5_SEQ_SUB_EN
  logic         sub;
`endif

  int n_cmp;
  int n_err;

  adder5_seq_ctrl #(.NCHUNK(NCHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef ADDER5_SEQ_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference: the whole operand added at once, carry-out as bit W.
  function automatic logic [W:0] model_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  // Issues one request and returns at the first falling edge with out_valid high.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                        output logic [W-1:0] s_o, output logic c_o, output int lat,
                        output bit ok);
    int n;
    @(negedge clk);
    a = av; b = bv; cin = ci; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    cin = 1'($urandom);
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    s_o = sum;
    c_o = cout;
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #2;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (sum !== '0) begin n_err++; $display("FAIL reset_sum got %h want 0", sum); end
    n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL reset_cout got %b want 0", cout); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [W-1:0] s; logic c; int lat; bit ok;
    out_ready = 1'b1;
    run_op(20'h12345, 20'h0ABCD, 1'b0, s, c, lat, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL basic_accept got %b want 1", ok); end
    n_cmp++; if (lat != NCHUNK) begin n_err++; $display("FAIL basic_latency got %0d want %0d", lat, NCHUNK); end
    n_cmp++; if (s !== 20'h1CF12) begin n_err++; $display("FAIL basic_sum got %h want 1cf12", s); end
    n_cmp++; if (c !== 1'b0) begin n_err++; $display("FAIL basic_cout got %b want 0", c); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_done got %b want 1", busy); end
    @(negedge clk);
  endtask

  task automatic test_carry_ripple;
    logic [W-1:0] s; logic c; int lat; bit ok;
    out_ready = 1'b1;
    run_op(20'hFFFFF, 20'h00000, 1'b1, s, c, lat, ok);
    n_cmp++; if (s !== 20'h00000) begin n_err++; $display("FAIL ripple_sum got %h want 00000", s); end
    n_cmp++; if (c !== 1'b1) begin n_err++; $display("FAIL ripple_cout got %b want 1", c); end
    @(negedge clk);
  endtask

  task automatic test_hold_done;
    logic [W-1:0] s; logic c; int lat; bit ok;
    logic [W-1:0] av, bv; logic ci; logic [W:0] exp;
    av = W'($urandom); bv = W'($urandom); ci = 1'($urandom);
    exp = model_add(av, bv, ci);
    out_ready = 1'b0;
    run_op(av, bv, ci, s, c, lat, ok);
    n_cmp++; if ({c, s} !== exp) begin n_err++; $display("FAIL hold_result got %h want %h", {c, s}, exp); end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
      @(posedge clk);
      @(negedge clk);
      n_cmp++; if ({cout, sum} !== exp) begin n_err++; $display("FAIL hold_stable[%0d] got %h want %h", i, {cout, sum}, exp); end
      n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_err++; $display("FAIL hold_handshake[%0d] got in_ready=%b out_valid=%b want 0/1", i, in_ready, out_valid); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL hold_release got in_ready=%b out_valid=%b busy=%b want 1/0/0", in_ready, out_valid, busy); end
    n_cmp++; if ({cout, sum} !== exp) begin n_err++; $display("FAIL hold_idle_sum got %h want %h", {cout, sum}, exp); end
  endtask

  task automatic test_reset_mid_run;
    logic [W-1:0] s; logic c; int lat; bit ok;
    out_ready = 1'b1;
    @(negedge clk);
    a = W'($urandom); b = W'($urandom); cin = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL midrun_busy got %b want 1", busy); end
    rst = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL midrun_ctrl got in_ready=%b out_valid=%b busy=%b want 1/0/0", in_ready, out_valid, busy); end
    n_cmp++; if (sum !== '0 || cout !== 1'b0) begin n_err++; $display("FAIL midrun_data got sum=%h cout=%b want 0/0", sum, cout); end
    @(negedge clk);
    rst = 1'b0;
    run_op(20'h00001, 20'h00001, 1'b0, s, c, lat, ok);
    n_cmp++; if (s !== 20'h00002 || c !== 1'b0) begin n_err++; $display("FAIL midrun_after got sum=%h cout=%b want 00002/0", s, c); end
    n_cmp++; if (lat != NCHUNK) begin n_err++; $display("FAIL midrun_latency got %0d want %0d", lat, NCHUNK); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [W:0] q[$];
    int acc[$];
    int cyc, nacc, nres;
    logic [W:0] exp;
    out_ready = 1'b1;
    @(negedge clk);
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); in_valid = 1'b1;
    cyc = 0; nacc = 0; nres = 0;
    while ((nacc < 5 || q.size() > 0) && cyc < 200) begin
      if (out_valid) begin
        nres++;
        if (q.size() == 0) begin
          n_cmp++; n_err++; $display("FAIL b2b_unexpected got %h want none", {cout, sum});
        end else begin
          exp = q.pop_front();
          n_cmp++; if ({cout, sum} !== exp) begin n_err++; $display("FAIL b2b_result[%0d] got %h want %h", nres, {cout, sum}, exp); end
        end
      end
      if (in_ready && in_valid) begin
        q.push_back(model_add(a, b, cin));
        acc.push_back(cyc);
        nacc++;
      end
      @(posedge clk);
      #1;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      if (nacc >= 5) in_valid = 1'b0;
      @(negedge clk);
      cyc++;
    end
    n_cmp++; if (nres != 5 || q.size() != 0) begin n_err++; $display("FAIL b2b_count got %0d results want 5", nres); end
    for (int i = 1; i < acc.size(); i++) begin
      n_cmp++; if (acc[i] - acc[i-1] != NCHUNK + 2) begin n_err++; $display("FAIL b2b_spacing[%0d] got %0d want %0d", i, acc[i] - acc[i-1], NCHUNK + 2); end
    end
  endtask

  task automatic test_random;
    logic [W-1:0] s; logic c; int lat; bit ok;
    logic [W-1:0] av, bv; logic ci; logic [W:0] exp; int stall;
    for (int i = 0; i < 12; i++) begin
      av = (i == 0) ? 20'hFFFFF : W'($urandom);
      bv = (i == 0) ? 20'hFFFFF : W'($urandom);
      ci = 1'($urandom);
      exp = model_add(av, bv, ci);
      stall = $urandom_range(0, 3);
      out_ready = (stall == 0);
      run_op(av, bv, ci, s, c, lat, ok);
      n_cmp++; if ({c, s} !== exp || lat != NCHUNK) begin n_err++; $display("FAIL random[%0d] got %h lat %0d want %h lat %0d", i, {c, s}, lat, exp, NCHUNK); end
      for (int k = 0; k < stall; k++) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
    end
  endtask

`ifdef ADDER5_SEQ_SUB_EN
  task automatic test_sub;
    logic [W-1:0] s; logic c; int lat; bit ok;
    out_ready = 1'b1;
    sub = 1'b1;
    run_op(20'h00005, 20'h00007, 1'($urandom), s, c, lat, ok);
    n_cmp++; if (s !== 20'hFFFFE || c !== 1'b0) begin n_err++; $display("FAIL sub_neg got sum=%h cout=%b want FFFFE/0", s, c); end
    @(negedge clk);
    run_op(20'h00007, 20'h00005, 1'($urandom), s, c, lat, ok);
    n_cmp++; if (s !== 20'h00002 || c !== 1'b1) begin n_err++; $display("FAIL sub_pos got sum=%h cout=%b want 00002/1", s, c); end
    @(negedge clk);
    sub = 1'b0;
  endtask
`endif

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0;
`ifdef ADDER5_SEQ_SUB_EN
    sub = 1'b0;
`endif
    test_reset;
    test_basic;
    test_carry_ripple;
    test_hold_done;
    test_reset_mid_run;
    test_back_to_back;
    test_random;
`ifdef ADDER5_SEQ_SUB_EN
    test_sub;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
